// File: rtl/bridge_pkg.sv
// Shared definitions for the UART bridge slave controller: FSM encoding, frame mode bits
// and frame field offsets.
package bridge_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WLOAD  = 3'd1,
        TXWAIT = 3'd2,
        RSEND  = 3'd3,
        RWAIT  = 3'd4
    } state_t;

    localparam logic MODE_WR = 1'b1;
    localparam logic MODE_RD = 1'b0;

    // TX frame layout, LSB first: addr, data, mode, tag, zero pad
    function automatic int addr_lsb();
        return 0;
    endfunction

    function automatic int data_lsb(input int aw);
        return aw;
    endfunction

    function automatic int mode_bit(input int aw, input int dw);
        return aw + dw;
    endfunction

    function automatic int tag_lsb(input int aw, input int dw);
        return aw + dw + 1;
    endfunction

endpackage

// File: rtl/bridge_wr_fifo.sv
// Posted-write queue: synchronous FIFO with wrap-bit pointers and a combinational
// head read, so the head entry is visible in the same cycle it is popped.
module bridge_wr_fifo
    import bridge_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[PW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign rdata = mem[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/uart_bridge_slave_ctrl.sv
// Memory-side bridge controller: queues posted writes, serialises tagged UART frames and
// matches tagged read responses. Define BRIDGE_TIMEOUT_EN to enable the read timeout.
module uart_bridge_slave_ctrl
    import bridge_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int TAG_WIDTH   = 4,
    parameter int WQ_DEPTH    = 4,
    parameter int TX_WIDTH    = 32,
    parameter int RX_WIDTH    = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_wen,
    input  logic                  mem_ren,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wack,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rvalid,
    output logic                  rd_err,
    output logic                  ready,
    output logic [TX_WIDTH-1:0]   u_din,
    output logic                  u_en,
    input  logic                  u_tx_busy,
    input  logic                  u_rx_ready,
    input  logic [RX_WIDTH-1:0]   u_dout
);

    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
    localparam int A_LSB   = addr_lsb();
    localparam int D_LSB   = data_lsb(ADDR_WIDTH);
    localparam int M_BIT   = mode_bit(ADDR_WIDTH, DATA_WIDTH);
    localparam int T_LSB   = tag_lsb(ADDR_WIDTH, DATA_WIDTH);

    state_t               state;
    logic [TAG_WIDTH-1:0] tag;
    logic                 rd_pending;
    logic                 fifo_push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   fifo_head;
    logic                 rx_match;
    logic                 timed_out;

    function automatic logic [TX_WIDTH-1:0] make_frame(
        input logic                  mode,
        input logic [TAG_WIDTH-1:0]  t,
        input logic [DATA_WIDTH-1:0] d,
        input logic [ADDR_WIDTH-1:0] a
    );
        logic [TX_WIDTH-1:0] f;
        f                        = '0;
        f[A_LSB +: ADDR_WIDTH]   = a;
        f[D_LSB +: DATA_WIDTH]   = d;
        f[M_BIT]                 = mode;
        f[T_LSB +: TAG_WIDTH]    = t;
        return f;
    endfunction

    // A write already acknowledged is still held high for one cycle; do not push it twice.
    assign fifo_push = mem_wen && !mem_ren && !mem_wack && !fifo_full;
    assign rx_match  = u_rx_ready && (u_dout[DATA_WIDTH +: TAG_WIDTH] == tag);
    assign ready     = !fifo_full && (state == IDLE) && !mem_wen && !mem_ren;

    bridge_wr_fifo #(
        .DEPTH (WQ_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_wr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (state == WLOAD),
        .wdata ({mem_addr, mem_wdata}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] to_cnt;

    assign timed_out = (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || state != RWAIT) to_cnt <= '0;
        else if (!timed_out)       to_cnt <= to_cnt + 1'b1;
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYC);
    assign timed_out      = 1'b0;
`endif

    if (RX_WIDTH > TAG_WIDTH + DATA_WIDTH) begin : g_rx_pad
        logic unused_rx_pad;
        assign unused_rx_pad = ^u_dout[RX_WIDTH-1:TAG_WIDTH+DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tag        <= '0;
            rd_pending <= 1'b0;
            u_din      <= '0;
            u_en       <= 1'b0;
            mem_wack   <= 1'b0;
            mem_rdata  <= '0;
            mem_rvalid <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle and are raised only by the state that owns them.
            mem_wack   <= fifo_push;
            u_en       <= 1'b0;
            mem_rvalid <= 1'b0;
            rd_err     <= 1'b0;
            case (state)
                IDLE: begin
                    // mem_ren is still high during the rvalid cycle; do not restart that read.
                    if (!fifo_empty)                  state <= WLOAD;
                    else if (mem_ren && !mem_rvalid) state <= RSEND;
                end
                WLOAD: begin
                    u_din      <= make_frame(MODE_WR, tag, fifo_head[DATA_WIDTH-1:0],
                                             fifo_head[ENTRY_W-1 -: ADDR_WIDTH]);
                    u_en       <= 1'b1;
                    rd_pending <= 1'b0;
                    state      <= TXWAIT;
                end
                RSEND: begin
                    u_din      <= make_frame(MODE_RD, tag, '0, mem_addr);
                    u_en       <= 1'b1;
                    rd_pending <= 1'b1;
                    state      <= TXWAIT;
                end
                TXWAIT: begin
                    // Busy cannot reflect the launch yet while u_en is still high.
                    if (!u_en && !u_tx_busy) state <= rd_pending ? RWAIT : IDLE;
                end
                RWAIT: begin
                    if (rx_match) begin
                        mem_rdata  <= u_dout[DATA_WIDTH-1:0];
                        mem_rvalid <= 1'b1;
                        tag        <= tag + 1'b1;
                        state      <= IDLE;
                    end else if (timed_out) begin
                        mem_rdata  <= '0;
                        mem_rvalid <= 1'b1;
                        rd_err     <= 1'b1;
                        tag        <= tag + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
